// File: rtl/pulse_to_level.sv
// Converts single-cycle event pulses into high/low level phases, one high phase per accepted event.
// Latency: sig rises one cycle after an idle pulse; queued events wait in a saturating pending counter.
module pulse_to_level #(
   parameter int CNT_W  = 8,
   parameter int PEND_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pulse,
   input  logic [CNT_W-1:0]  high_len,
   input  logic [CNT_W-1:0]  low_len,
   output logic              sig,
   output logic              busy,
   output logic [PEND_W-1:0] pending,
   output logic              overflow
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] HIGH = 2'd1;
   localparam logic [1:0] LOW  = 2'd2;

   localparam logic [CNT_W-1:0]  ONE_C    = 1;
   localparam logic [PEND_W-1:0] ONE_P    = 1;
   localparam logic [PEND_W-1:0] PEND_MAX = '1;

   logic [1:0]        state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [CNT_W-1:0]  hi_eff, lo_eff;
   logic [PEND_W-1:0] pend_nxt;
   logic              ovf_nxt;
   logic              last_cyc;

   assign hi_eff   = (high_len == '0) ? ONE_C : high_len;
   assign lo_eff   = (low_len  == '0) ? ONE_C : low_len;
   assign last_cyc = (cnt <= ONE_C);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      pend_nxt  = pending;
      ovf_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (pulse) begin
               state_nxt = HIGH;
               cnt_nxt   = hi_eff;
            end
         end
         HIGH, LOW: begin
            if (last_cyc && state == HIGH) begin
               state_nxt = LOW;
               cnt_nxt   = lo_eff;
            end else if (!last_cyc) begin
               cnt_nxt = cnt - ONE_C;
            end
            if (last_cyc && state == LOW) begin
               // A pulse in the final low cycle cancels against the dequeue.
               if (pending != '0) begin
                  state_nxt = HIGH;
                  cnt_nxt   = hi_eff;
                  if (!pulse)
                     pend_nxt = pending - ONE_P;
               end else if (pulse) begin
                  state_nxt = HIGH;
                  cnt_nxt   = hi_eff;
               end else begin
                  state_nxt = IDLE;
                  cnt_nxt   = '0;
               end
            end else if (pulse) begin
               if (pending == PEND_MAX)
                  ovf_nxt = 1'b1;
               else
                  pend_nxt = pending + ONE_P;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         pending  <= '0;
         overflow <= 1'b0;
         sig      <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         pending  <= pend_nxt;
         overflow <= ovf_nxt;
         sig      <= (state_nxt == HIGH);
         busy     <= (state_nxt != IDLE);
      end
   end

endmodule
